// File: rtl/corefifo_vdma_pkg.sv
// Shared constants and pointer-code helpers for the VDMA FIFO pointer converter.
// Helpers work on a wide container; callers zero-extend in and truncate out.
package corefifo_vdma_pkg;

    localparam int MODE_G2B = 0;
    localparam int MODE_B2G = 1;
    localparam int PTR_MAX  = 16;

    typedef logic [PTR_MAX-1:0] ptr_t;

    // Zero upper bits in give zero upper bits out, so any W <= PTR_MAX is exact.
    function automatic ptr_t gray2bin(ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/corefifo_gray_step_chk_vdma.sv
// One channel of the pointer step checker: history, modular delta and a sticky flag.
// Legal steps are 0 and +1 modulo 2^W; the first beat after reset or clear only loads history.
module corefifo_gray_step_chk_vdma #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid,
    input  logic         clr,
    input  logic [W-1:0] bin,
    output logic         err
);

    logic [W-1:0] last;
    logic [W-1:0] delta;
    logic         have;
    logic         bad;

    assign delta = bin - last;
    assign bad   = valid & have & (delta > W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last <= '0;
            have <= 1'b0;
            err  <= 1'b0;
        end else begin
            // A fresh violation outranks a clear in the same cycle.
            err  <= bad | (err & ~clr);
            have <= clr ? 1'b0 : (have | valid);
            if (valid) begin
                last <= bin;
            end
        end
    end

endmodule

// File: rtl/corefifo_gray_conv_pipe_vdma.sv
// Registered multi-channel Gray<->binary pointer converter with a 2-entry skid buffer
// and optional per-channel step checker, for the synchronised-pointer path of a VDMA FIFO.
module corefifo_gray_conv_pipe_vdma
    import corefifo_vdma_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int NUM_CH    = 1,
    parameter int MODE      = 0,
    parameter int CHECK_EN  = 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0] out_data,
    input  logic                            clr_err,
    output logic [NUM_CH-1:0]               step_err
);

    localparam int W  = ADDRWIDTH + 1;
    localparam int DW = NUM_CH * W;

    logic [DW-1:0] conv_data;
    logic [DW-1:0] bin_data;
    logic          accept;
    logic          out_free;
    logic          skid_valid;
    logic [DW-1:0] skid_data;
    logic          out_valid_n;
    logic [DW-1:0] out_data_n;
    logic          skid_valid_n;
    logic [DW-1:0] skid_data_n;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_conv
        ptr_t in_ext;
        ptr_t conv_ext;
        logic unused_conv;

        assign in_ext      = ptr_t'(in_data[k*W +: W]);
        assign unused_conv = ^conv_ext;

        if (MODE == MODE_B2G) begin : g_b2g
            assign conv_ext            = bin2gray(in_ext);
            assign bin_data[k*W +: W]  = in_data[k*W +: W];
        end else begin : g_g2b
            assign conv_ext            = gray2bin(in_ext);
            assign bin_data[k*W +: W]  = conv_ext[W-1:0];
        end

        assign conv_data[k*W +: W] = conv_ext[W-1:0];
    end

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (out_free) begin
            if (skid_valid) begin
                out_valid_n  = 1'b1;
                out_data_n   = skid_data;
                skid_valid_n = accept;
                if (accept) begin
                    skid_data_n = conv_data;
                end
            end else begin
                out_valid_n = accept;
                if (accept) begin
                    out_data_n = conv_data;
                end
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = conv_data;
        end
    end

    // in_ready is registered from the next skid state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            in_ready   <= ~skid_valid_n;
        end
    end

    if (CHECK_EN != 0) begin : g_chk
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            corefifo_gray_step_chk_vdma #(
                .W(W)
            ) u_chk (
                .clk  (clk),
                .rstn (rstn),
                .valid(accept),
                .clr  (clr_err),
                .bin  (bin_data[k*W +: W]),
                .err  (step_err[k])
            );
        end
    end else begin : g_nochk
        logic unused_chk;
        assign unused_chk = ^{bin_data, clr_err};
        assign step_err   = '0;
    end

endmodule

// File: tb/tb_corefifo_gray_conv_pipe_vdma.sv
// Bench for the pointer converter: a Gray->binary and a binary->Gray instance share stimulus
// and are compared every cycle against a queue/occupancy reference model.
module tb_corefifo_gray_conv_pipe_vdma;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       clr_err;

    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0] a_out_data, b_out_data;
    logic [1:0] a_step_err, b_step_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: held beats per instance, ready flag, checker history per instance/channel.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         rdy_m = 1'b0;
    int         last_m[2][2];
    bit         have_m[2][2];
    bit [1:0]   err_m[2];

    always #5 clk = ~clk;

    corefifo_gray_conv_pipe_vdma #(.ADDRWIDTH(3), .NUM_CH(2), .MODE(0), .CHECK_EN(1)) dut_g2b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .clr_err(clr_err), .step_err(a_step_err)
    );

    corefifo_gray_conv_pipe_vdma #(.ADDRWIDTH(3), .NUM_CH(2), .MODE(1), .CHECK_EN(1)) dut_b2g (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .clr_err(clr_err), .step_err(b_step_err)
    );

    function automatic int g2b(int g);
        int b = 0;
        for (int i = 0; i < 4; i++) b = b ^ (g >> i);
        return b & 15;
    endfunction

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic logic [7:0] conv(int mode, logic [7:0] d);
        int hi = int'(d[7:4]);
        int lo = int'(d[3:0]);
        if (mode == 1) return {4'(b2g(hi)), 4'(b2g(lo))};
        return {4'(g2b(hi)), 4'(g2b(lo))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model across the rising edge, then compare at the falling edge.
    task automatic step(input bit rv, input bit v, input logic [7:0] d, input bit r, input bit c);
        bit acc, ema, emb;
        rstn = rv; in_valid = v; in_data = d; out_ready = r; clr_err = c;
        acc = rv & v & rdy_m;
        ema = rv & r & (qa.size() > 0);
        emb = rv & r & (qb.size() > 0);
        if (!rv) begin
            qa.delete(); qb.delete();
            rdy_m = 1'b0;
            for (int m = 0; m < 2; m++) begin
                err_m[m] = 2'b00;
                for (int ch = 0; ch < 2; ch++) begin
                    have_m[m][ch] = 1'b0;
                    last_m[m][ch] = 0;
                end
            end
        end else begin
            if (ema) void'(qa.pop_front());
            if (emb) void'(qb.pop_front());
            if (acc) begin
                qa.push_back(conv(0, d));
                qb.push_back(conv(1, d));
            end
            rdy_m = (qa.size() < 2);
            for (int m = 0; m < 2; m++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    int raw = (ch == 0) ? int'(d[3:0]) : int'(d[7:4]);
                    int val = (m == 0) ? g2b(raw) : raw;
                    bit bad = acc && have_m[m][ch] && (((val - last_m[m][ch]) & 15) > 1);
                    err_m[m][ch] = bad | (err_m[m][ch] & ~c);
                    have_m[m][ch] = c ? 1'b0 : (have_m[m][ch] | acc);
                    if (acc) last_m[m][ch] = val;
                end
            end
        end
        @(negedge clk);
        check("a_in_ready", a_in_ready, rdy_m);
        check("b_in_ready", b_in_ready, rdy_m);
        check("a_out_valid", a_out_valid, qa.size() > 0);
        check("b_out_valid", b_out_valid, qb.size() > 0);
        if (qa.size() > 0) check("a_out_data", a_out_data, qa[0]);
        if (qb.size() > 0) check("b_out_data", b_out_data, qb[0]);
        check("a_step_err", a_step_err, err_m[0]);
        check("b_step_err", b_step_err, err_m[1]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] src[16];
        logic [7:0] got[$];
        logic [7:0] prev;
        logic [3:0] walk[2];
        int sent, cyc;
        bit saw_stall, r, v, c;

        // Reset and idle
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("rst_out_data", a_out_data, 8'h00);
        check("rst_in_ready", a_in_ready, 1'b0);
        repeat (3) step(1, 0, 8'h00, 1, 0);

        // Gray->binary single beat, valid for exactly one cycle
        step(1, 1, 8'b0000_1101, 1, 0);
        check("t1_data", a_out_data, 8'b0000_1001);
        check("t1_valid", a_out_valid, 1'b1);
        step(1, 0, 8'h00, 1, 0);
        check("t1_valid_drop", a_out_valid, 1'b0);

        // Binary->Gray single beat and a 0..15 sweep with one-bit steps
        step(1, 1, 8'b0000_1001, 1, 0);
        check("t2_data", b_out_data[3:0], 4'b1101);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 8'(i), 1, 0);
            if (i > 0) check("t2_onebit", $countones(prev ^ b_out_data), 1);
            prev = b_out_data;
        end
        step(1, 0, 8'h00, 1, 0);

        // Stream 16 beats with out_ready low in cycles 3..5
        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        sent = 0; cyc = 0; saw_stall = 1'b0;
        while ((sent < 16 || qa.size() > 0) && cyc < 200) begin
            bit will_acc;
            r = !(cyc >= 3 && cyc <= 5);
            v = (sent < 16);
            if (a_out_valid && r) got.push_back(a_out_data);
            if (!a_in_ready) saw_stall = 1'b1;
            will_acc = v & rdy_m;
            step(1, v, (sent < 16) ? src[sent] : 8'h00, r, 0);
            if (will_acc) sent++;
            cyc++;
        end
        check("t3_stall_seen", saw_stall, 1'b1);
        check("t3_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("t3_order", got[i], conv(0, src[i]));

        // Step checker: wrap 15->0 legal, 0->2 illegal and sticky
        step(1, 0, 8'h00, 1, 1);
        step(1, 1, 8'b0000_1000, 1, 0);
        step(1, 1, 8'b0000_0000, 1, 0);
        check("t4_wrap_ok", a_step_err, 2'b00);
        step(1, 1, 8'b0000_0011, 1, 0);
        check("t4_err", a_step_err, 2'b01);
        repeat (3) step(1, 0, 8'h00, 1, 0);
        check("t4_sticky", a_step_err, 2'b01);
        step(1, 0, 8'h00, 1, 1);
        check("t4_clear", a_step_err, 2'b00);

        // Clear coinciding with an illegal beat, then history reload after a plain clear
        step(1, 1, 8'h00, 1, 0);
        step(1, 1, 8'b0101_0000, 1, 1);
        check("t5_err_wins", a_step_err, 2'b10);
        step(1, 0, 8'h00, 1, 1);
        check("t5_cleared", a_step_err, 2'b00);
        step(1, 1, 8'b1100_1010, 1, 0);
        check("t5_reload", a_step_err, 2'b00);

        // Reset with skid full and output stalled
        step(1, 0, 8'h00, 1, 0);
        step(1, 1, 8'h00, 0, 0);
        step(1, 1, 8'h55, 0, 0);
        check("t6_full", a_in_ready, 1'b0);
        step(0, 0, 8'h00, 0, 0);
        check("t6_valid", a_out_valid, 1'b0);
        check("t6_err", a_step_err, 2'b00);
        check("t6_data", a_out_data, 8'h00);
        step(1, 0, 8'h00, 0, 0);
        check("t6_ready", a_in_ready, 1'b1);

        // Randomized traffic on a mostly-monotonic pointer walk
        walk[0] = 4'h0; walk[1] = 4'h0;
        for (int n = 0; n < 1500; n++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(9) == 0) walk[ch] = 4'($urandom);
                else walk[ch] = walk[ch] + 4'($urandom_range(1));
            end
            v = ($urandom_range(3) != 0);
            r = ($urandom_range(2) != 0);
            c = ($urandom_range(39) == 0);
            step(($urandom_range(299) != 0), v, {4'(b2g(int'(walk[1]))), 4'(b2g(int'(walk[0])))}, r, c);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
